multicycle_ctrl: RTL and testbench

- Moore-style main controller FSM for the multicycle RISC-V datapath.
- Sequences one instruction over 3–5 cycles.
- Drives the select inputs of the datapath's 2:1 and 4:1 32-bit muxes (address, ALU A/B operand, result), plus the register-file, memory and PC write enables.
- Stalls on a memory ready handshake and traps on unsupported opcodes.

---
 rtl/riscv_ctrl_pkg.sv | 125 ++++++++++++
 rtl/multicycle_ctrl_next.sv | 53 +++++
 rtl/multicycle_ctrl.sv | 63 ++++++
 tb/tb_multicycle_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller and datapath:
// opcodes, controller states, mux select codes and the per-state output decode.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    // fetch/branch are raw decode bits; the top qualifies them with MemReady/Zero
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_decode(input logic [3:0] state);
        ctrl_t c;
        c = '0;
        case (state)
            S_FETCH: begin
                c.adr_src    = ADR_PC;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.adr_src    = ADR_ALUOUT;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = ADR_ALUOUT;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_RS2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_next.sv
// Next-state function of the multicycle controller: state, opcode and
// memory handshake in, next state out. Purely combinational.
module multicycle_ctrl_next
    import riscv_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [6:0] op,
    input  logic       mem_ready,
    output state_t     next_state
);

    // transition table; unknown opcodes and unused codes collapse into TRAP
    always_comb begin
        next_state = S_TRAP;
        case (state)
            S_FETCH: begin
                if (mem_ready) next_state = S_DECODE;
                else           next_state = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYP:      next_state = S_EXECR;
                    OP_IALU:      next_state = S_EXECI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      next_state = S_MEMREAD;
                else if (op == OP_SW) next_state = S_MEMWRITE;
                else                  next_state = S_TRAP;
            end
            S_MEMREAD: begin
                if (mem_ready) next_state = S_MEMWB;
                else           next_state = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready) next_state = S_FETCH;
                else           next_state = S_MEMWRITE;
            end
            S_MEMWB:  next_state = S_FETCH;
            S_EXECR:  next_state = S_ALUWB;
            S_EXECI:  next_state = S_ALUWB;
            S_JAL:    next_state = S_ALUWB;
            S_ALUWB:  next_state = S_FETCH;
            S_BEQ:    next_state = S_FETCH;
            default:  next_state = S_TRAP;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle RISC-V datapath. Select outputs are
// a registered decode of the state; enables are gated by MemReady, Zero and reset.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         Op,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic               RegWrite,
    output logic               Illegal,
    output logic [STATE_W-1:0] StateOut
);

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    logic   run_s;

    multicycle_ctrl_next u_next (
        .state      (state_r),
        .op         (Op),
        .mem_ready  (MemReady),
        .next_state (next_state_s)
    );

    // state register; ctrl_r holds the decode of the state being entered so it always matches state_r
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
            ctrl_r  <= ctrl_decode(S_FETCH);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_decode(next_state_s);
        end
    end

    assign run_s = ~reset;

    assign PCWrite   = run_s & ((ctrl_r.fetch & MemReady) | ctrl_r.pc_update | (ctrl_r.branch & Zero));
    assign IRWrite   = run_s & ctrl_r.fetch & MemReady;
    assign MemWrite  = run_s & ctrl_r.mem_write;
    assign RegWrite  = run_s & ctrl_r.reg_write;
    assign AdrSrc    = ctrl_r.adr_src;
    assign ResultSrc = ctrl_r.result_src;
    assign ALUSrcA   = ctrl_r.alu_src_a;
    assign ALUSrcB   = ctrl_r.alu_src_b;
    assign ALUOp     = ctrl_r.alu_op;
    assign Illegal   = ctrl_r.illegal;
    assign StateOut  = STATE_W'(state_r);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed vector table, trap/reset sequences,
// and randomized instruction streams checked against an instruction-level model.
module tb_multicycle_ctrl;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset, Zero, MemReady;
    logic [6:0] Op;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] StateOut;
    logic [17:0] obs;

    int checks = 0;
    int failures = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegWrite(RegWrite), .Illegal(Illegal), .StateOut(StateOut)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUOp, RegWrite, Illegal, StateOut};

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic       pcw, irw, mw, rw, ill;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic mr, input logic z,
                                input logic [3:0] st, input logic pcw, input logic irw,
                                input logic mw, input logic rw, input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.mr = mr; v.z = z; v.st = st;
        v.pcw = pcw; v.irw = irw; v.mw = mw; v.rw = rw; v.ill = ill;
        return v;
    endfunction

    // Expected outputs for a state code, straight from the per-state output table.
    function automatic logic [17:0] exp_out(input int code, input logic mr, input logic z, input logic rst);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, aop;
        pcw = 1'b0; adr = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0; ill = 1'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
        case (code)
            0:  begin sb = 2'b10; rs = 2'b10; pcw = mr; irw = mr; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin adr = 1'b1; end
            4:  begin rs = 2'b01; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'b10; aop = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            8:  begin rw = 1'b1; end
            9:  begin sa = 2'b10; aop = 2'b01; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            default: ill = 1'b1;
        endcase
        if (rst) begin
            pcw = 1'b0; mw = 1'b0; irw = 1'b0; rw = 1'b0;
        end
        return {pcw, adr, mw, irw, rs, sa, sb, aop, rw, ill, 4'(code)};
    endfunction

    // Instruction-level reference: the state code visited at each step of an instruction.
    function automatic int seq_len(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW, RT, IT, JAL: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int seq_code(input logic [6:0] op, input int idx);
        int s[5];
        case (op)
            LW:      s = '{0, 1, 2, 3, 4};
            SW:      s = '{0, 1, 2, 5, 0};
            RT:      s = '{0, 1, 6, 8, 0};
            IT:      s = '{0, 1, 7, 8, 0};
            BEQ:     s = '{0, 1, 9, 0, 0};
            JAL:     s = '{0, 1, 10, 8, 0};
            default: s = '{0, 1, 11, 11, 11};
        endcase
        return s[idx];
    endfunction

    function automatic logic [6:0] pick_op();
        logic [6:0] ops [6];
        logic [6:0] o;
        ops = '{LW, SW, RT, IT, BEQ, JAL};
        if ($urandom_range(0, 99) < 6) begin
            o = 7'($urandom_range(0, 127));
            if (o == LW || o == SW || o == RT || o == IT || o == BEQ || o == JAL) o = BAD;
            return o;
        end
        return ops[$urandom_range(0, 5)];
    endfunction

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [6:0] op, input logic mr, input logic z);
        @(negedge clk);
        reset = r; Op = op; MemReady = mr; Zero = z;
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b1; Op = LW; MemReady = 1'b0; Zero = 1'b0;

        // lw, zero wait
        tbl.push_back(mk(0, LW, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 4, 0, 0, 0, 1, 0));
        // sw with two stalled write cycles
        tbl.push_back(mk(0, SW, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, SW, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, SW, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, SW, 0, 0, 5, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, SW, 0, 0, 5, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, SW, 1, 0, 5, 0, 0, 1, 0, 0));
        // beq taken, then not taken
        tbl.push_back(mk(0, BEQ, 1, 1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, BEQ, 1, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, BEQ, 1, 1, 9, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, BEQ, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, BEQ, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, BEQ, 1, 0, 9, 0, 0, 0, 0, 0));
        // jal, R-type, I-ALU
        tbl.push_back(mk(0, JAL, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, JAL, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, JAL, 1, 0, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, JAL, 1, 0, 8, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, RT, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, RT, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, RT, 0, 1, 6, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, RT, 0, 1, 8, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, IT, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, IT, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, IT, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, IT, 1, 0, 7, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, IT, 1, 0, 8, 0, 0, 0, 1, 0));
        // reset while lw is stalled in MEMREAD
        tbl.push_back(mk(0, LW, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 0, 0, 3, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, LW, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, LW, 1, 0, 0, 1, 1, 0, 0, 0));

        // power-on reset: enables must be low even before the state is known
        drive(1, LW, 1, 1);
        check("reset_enables", {14'd0, PCWrite, MemWrite, IRWrite, RegWrite}, 18'd0);
        drive(1, LW, 1, 1);
        check("reset_state", obs, exp_out(0, 1'b1, 1'b1, 1'b1));

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].mr, tbl[i].z);
            check($sformatf("vec%0d_enables", i),
                  {9'd0, PCWrite, IRWrite, MemWrite, RegWrite, Illegal, StateOut},
                  {9'd0, tbl[i].pcw, tbl[i].irw, tbl[i].mw, tbl[i].rw, tbl[i].ill, tbl[i].st});
            check($sformatf("vec%0d_full", i), obs,
                  exp_out(int'(tbl[i].st), tbl[i].mr, tbl[i].z, tbl[i].rst));
        end

        // illegal opcode: trap is absorbing until reset
        drive(1, BAD, 1, 0);
        check("trap_pre_reset", {14'd0, PCWrite, MemWrite, IRWrite, RegWrite}, 18'd0);
        drive(0, BAD, 1, 0);
        check("trap_fetch", obs, exp_out(0, 1'b1, 1'b0, 1'b0));
        drive(0, BAD, 1, 0);
        check("trap_decode", obs, exp_out(1, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 20; k++) begin
            logic mr, z;
            mr = 1'($urandom_range(0, 1));
            z  = 1'($urandom_range(0, 1));
            drive(0, BAD, mr, z);
            check($sformatf("trap_hold%0d", k), obs, exp_out(11, mr, z, 1'b0));
        end
        drive(1, BAD, 1, 1);
        check("trap_reset", obs, exp_out(11, 1'b1, 1'b1, 1'b1));
        drive(0, BAD, 0, 0);
        check("trap_exit", obs, exp_out(0, 1'b0, 1'b0, 1'b0));

        // randomized instruction stream vs instruction-level model (DUT now in FETCH)
        begin
            int idx;
            int code;
            logic [6:0] cur_op;
            logic r, mr, z, stall;
            idx = 0;
            cur_op = pick_op();
            for (int c = 0; c < 3000; c++) begin
                code = seq_code(cur_op, idx);
                r  = (code == 11) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
                mr = ($urandom_range(0, 3) != 0);
                z  = 1'($urandom_range(0, 1));
                drive(r, cur_op, mr, z);
                check($sformatf("rand%0d_op%b", c, cur_op), obs, exp_out(code, mr, z, r));
                stall = (code == 11) || (!mr && (code == 0 || code == 3 || code == 5));
                if (r) begin
                    idx = 0;
                    cur_op = pick_op();
                end else if (!stall) begin
                    idx++;
                    if (idx == seq_len(cur_op)) begin
                        idx = 0;
                        cur_op = pick_op();
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
